// File: rtl/lbp_window_fetch.sv
// Window fetch controller for the LBP engine: walks interior centre pixels in raster
// order, reads each 3x3 neighbourhood from gray memory and hands it downstream.
module lbp_window_fetch #(
   parameter int IMG_W = 128,
   parameter int IMG_H = 128,
   parameter int AW    = 14
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          gray_ready,
   output logic          gray_req,
   output logic [AW-1:0] gray_addr,
   output logic [8:0]    En,
   output logic          win_valid,
   output logic [AW-1:0] center_addr,
   input  logic          win_ack,
   output logic          finish
);

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, VALID, DONE} state_t;

   localparam logic [AW-1:0] W1       = AW'(IMG_W);
   localparam logic [AW-1:0] W2       = W1 << 1;
   localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 2);
   localparam logic [AW-1:0] ROW_LAST = AW'(IMG_H - 2);

   state_t        state, state_n;
   logic [3:0]    k, k_n;
   logic [AW-1:0] row, row_n, col, col_n;
   logic [AW-1:0] tl, tl_n;   // address of the window's top-left pixel

   logic          req_n, valid_n, finish_n;
   logic [AW-1:0] addr_n, center_n;
   logic [8:0]    en_n;

   function automatic logic [AW-1:0] win_addr(input logic [AW-1:0] base, input logic [3:0] kk);
      logic [AW-1:0] ro;
      logic [1:0]    co;
      unique case (kk)
         4'd0, 4'd1, 4'd2: ro = '0;
         4'd3, 4'd4, 4'd5: ro = W1;
         default:          ro = W2;
      endcase
      unique case (kk)
         4'd0, 4'd3, 4'd6: co = 2'd0;
         4'd1, 4'd4, 4'd7: co = 2'd1;
         default:          co = 2'd2;
      endcase
      return base + ro + AW'(co);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         k           <= '0;
         row         <= AW'(1);
         col         <= AW'(1);
         tl          <= '0;
         gray_req    <= 1'b0;
         gray_addr   <= '0;
         En          <= '0;
         win_valid   <= 1'b0;
         center_addr <= '0;
         finish      <= 1'b0;
      end else begin
         state       <= state_n;
         k           <= k_n;
         row         <= row_n;
         col         <= col_n;
         tl          <= tl_n;
         gray_req    <= req_n;
         gray_addr   <= addr_n;
         En          <= en_n;
         win_valid   <= valid_n;
         center_addr <= center_n;
         finish      <= finish_n;
      end
   end

   // Outputs are computed for the next state so every port comes straight from a flop.
   always_comb begin
      state_n  = state;
      k_n      = k;
      row_n    = row;
      col_n    = col;
      tl_n     = tl;
      req_n    = 1'b0;
      addr_n   = gray_addr;
      en_n     = '0;
      valid_n  = 1'b0;
      center_n = '0;
      finish_n = 1'b0;

      unique case (state)
         IDLE: begin
            if (gray_ready) begin
               state_n = FETCH;
               k_n     = '0;
               req_n   = 1'b1;
               addr_n  = win_addr(tl, 4'd0);
            end
         end
         FETCH: begin
            en_n = 9'(1) << k;
            if (k == 4'd8) begin
               state_n = DRAIN;
            end else begin
               k_n    = k + 4'd1;
               req_n  = 1'b1;
               addr_n = win_addr(tl, k + 4'd1);
            end
         end
         DRAIN: begin
            state_n  = VALID;
            valid_n  = 1'b1;
            center_n = tl + W1 + AW'(1);
         end
         VALID: begin
            if (win_ack) begin
               if (row == ROW_LAST && col == COL_LAST) begin
                  state_n  = DONE;
                  finish_n = 1'b1;
                  addr_n   = '0;
               end else begin
                  state_n = FETCH;
                  k_n     = '0;
                  // Wrapping from the last interior column skips the two border pixels.
                  if (col == COL_LAST) begin
                     col_n = AW'(1);
                     row_n = row + AW'(1);
                     tl_n  = tl + AW'(3);
                  end else begin
                     col_n = col + AW'(1);
                     tl_n  = tl + AW'(1);
                  end
                  req_n  = 1'b1;
                  addr_n = tl_n;
               end
            end else begin
               valid_n  = 1'b1;
               center_n = center_addr;
            end
         end
         DONE: begin
            finish_n = 1'b1;
            addr_n   = '0;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lbp_window_fetch.sv
// Bench for lbp_window_fetch: a default 128x128 instance and a 4x4 instance share
// stimulus; expected per-cycle outputs come from a window-index arithmetic model.
module tb_lbp_window_fetch;

   typedef struct {
      int req;
      int addr;
      int en;
      int valid;
      int center;
      int fin;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        gray_ready;
   logic        win_ack;

   logic        b_req, b_valid, b_fin;
   logic [13:0] b_addr, b_center;
   logic [8:0]  b_en;
   logic        s_req, s_valid, s_fin;
   logic [3:0]  s_addr, s_center;
   logic [8:0]  s_en;

   int n_cmp = 0;
   int n_bad = 0;
   rec_t q_big[$];
   rec_t q_small[$];

   always #5 clk = ~clk;

   lbp_window_fetch #(.IMG_W(128), .IMG_H(128), .AW(14)) dut_big (
      .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(b_req),
      .gray_addr(b_addr), .En(b_en), .win_valid(b_valid), .center_addr(b_center),
      .win_ack(win_ack), .finish(b_fin)
   );

   lbp_window_fetch #(.IMG_W(4), .IMG_H(4), .AW(4)) dut_small (
      .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(s_req),
      .gray_addr(s_addr), .En(s_en), .win_valid(s_valid), .center_addr(s_center),
      .win_ack(win_ack), .finish(s_fin)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_rec(input string tag, input rec_t e, input int req, input int addr,
                          input int en, input int valid, input int center, input int fin);
      chk({tag, ".gray_req"}, req, e.req);
      chk({tag, ".gray_addr"}, addr, e.addr);
      chk({tag, ".En"}, en, e.en);
      chk({tag, ".win_valid"}, valid, e.valid);
      chk({tag, ".center_addr"}, center, e.center);
      chk({tag, ".finish"}, fin, e.fin);
   endtask

   // Model: window n has centre (1 + n/(W-2), 1 + n%(W-2)).
   function automatic int centre_of(input int w, input int n);
      return (1 + n / (w - 2)) * w + 1 + n % (w - 2);
   endfunction

   function automatic int addr_of(input int w, input int n, input int k);
      int r, c;
      r = 1 + n / (w - 2);
      c = 1 + n % (w - 2);
      return (r - 1 + k / 3) * w + (c - 1 + k % 3);
   endfunction

   function automatic void push_one(input int sel, input rec_t r);
      if (sel == 0) q_big.push_back(r);
      else          q_small.push_back(r);
   endfunction

   // Expected outputs of window n, from the fetch-start cycle to the last VALID cycle.
   function automatic void push_window(input int sel, input int w, input int h,
                                       input int n, input int waits, input int lim);
      rec_t r;
      rec_t recs[$];
      if (n >= (w - 2) * (h - 2)) begin
         r = '{0, 0, 0, 0, 0, 1};
         for (int i = 0; i < 11 + waits; i++) recs.push_back(r);
      end else begin
         for (int k = 0; k < 9; k++) begin
            r = '{1, addr_of(w, n, k), (k == 0) ? 0 : (1 << (k - 1)), 0, 0, 0};
            recs.push_back(r);
         end
         r = '{0, addr_of(w, n, 8), 256, 0, 0, 0};
         recs.push_back(r);
         for (int i = 0; i <= waits; i++) begin
            r = '{0, addr_of(w, n, 8), 0, 1, centre_of(w, n), 0};
            recs.push_back(r);
         end
      end
      for (int i = 0; i < recs.size() && i < lim; i++) push_one(sel, recs[i]);
   endfunction

   function automatic void push_idle(input int cycles);
      rec_t r;
      r = '{0, 0, 0, 0, 0, 0};
      for (int i = 0; i < cycles; i++) begin
         push_one(0, r);
         push_one(1, r);
      end
   endfunction

   // Called at the negedge before the posedge that starts window n; returns at the
   // negedge before the posedge on which win_ack=1 is sampled in VALID.
   task automatic run_window(input int n, input int waits, input bit hold);
      push_window(0, 128, 128, n, waits, 1000);
      push_window(1, 4, 4, n, waits, 1000);
      @(negedge clk);
      win_ack = hold;
      repeat (10 + waits) @(negedge clk);
      win_ack = 1'b1;
   endtask

   always @(posedge clk) begin : compare
      rec_t rb, rs;
      #1;
      if (q_big.size() > 0) begin
         rb = q_big.pop_front();
         chk_rec("big", rb, int'(b_req), int'(b_addr), int'(b_en), int'(b_valid),
                 int'(b_center), int'(b_fin));
      end
      if (q_small.size() > 0) begin
         rs = q_small.pop_front();
         chk_rec("small", rs, int'(s_req), int'(s_addr), int'(s_en), int'(s_valid),
                 int'(s_center), int'(s_fin));
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, " big req"}, int'(b_req), 0);
      chk({tag, " big addr"}, int'(b_addr), 0);
      chk({tag, " big En"}, int'(b_en), 0);
      chk({tag, " big valid"}, int'(b_valid), 0);
      chk({tag, " big center"}, int'(b_center), 0);
      chk({tag, " big finish"}, int'(b_fin), 0);
      chk({tag, " small En"}, int'(s_en), 0);
      chk({tag, " small finish"}, int'(s_fin), 0);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset      = 1'b0;
      gray_ready = 1'b0;
      win_ack    = 1'b0;

      // Hand-computed pins of the model itself
      chk("model first addr k8", addr_of(128, 0, 8), 258);
      chk("model wrap first addr", addr_of(128, 126, 0), 128);
      chk("model wrap centre", centre_of(128, 126), 257);
      chk("model last default centre", centre_of(128, 15875), 16254);
      chk("model small last centre", centre_of(4, 3), 10);

      #3;
      chk_all_zero("reset async");
      repeat (3) @(negedge clk);
      chk_all_zero("reset held");

      reset = 1'b1;
      push_idle(20);
      repeat (20) @(negedge clk);

      gray_ready = 1'b1;
      run_window(0, 7, 1'b0);
      chk("win0 centre", int'(b_center), 129);
      chk("win0 valid", int'(b_valid), 1);
      chk("win0 small centre", int'(s_center), 5);
      run_window(1, 0, 1'b1);
      chk("win1 centre", int'(b_center), 130);
      for (int n = 2; n < 128; n++) begin
         run_window(n, n % 3, 1'b0);
         if (n == 4) chk("small finish sticky", int'(s_fin), 1);
         if (n == 125) chk("row end centre", int'(b_center), 254);
         if (n == 126) chk("row wrap centre", int'(b_center), 257);
      end
      chk("small finish late", int'(s_fin), 1);

      // Abort mid-FETCH: window 128 is dropped right after its k=4 address
      push_window(0, 128, 128, 128, 0, 5);
      push_window(1, 4, 4, 128, 0, 5);
      @(negedge clk);
      win_ack = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      chk_all_zero("mid-fetch reset");
      gray_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      push_idle(3);
      repeat (3) @(negedge clk);

      gray_ready = 1'b1;
      run_window(0, 2, 1'b0);
      chk("restart centre", int'(b_center), 129);
      chk("restart small centre", int'(s_center), 5);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
